// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: address map, status bits, sequencer states and timing defaults for io_bridge
package io_bridge_pkg;
    localparam logic [15:0] IO_LED        = 16'h0000;
    localparam logic [15:0] IO_STATUS     = 16'h0001;
    localparam logic [15:0] IO_FIFO_COUNT = 16'h0002;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int DEF_FIFO_DEPTH   = 16;
    localparam int DEF_E_PULSE      = 12;
    localparam int DEF_NIBBLE_GAP   = 50;
    localparam int DEF_BYTE_GAP     = 2000;
    localparam int DEF_POWERUP_WAIT = 750000;
    localparam int DEF_INIT_GAP     = 205000;
    typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_HI, S_GAP, S_LO, S_WAIT} seq_state_t;
endpackage

// File: rtl/lcd_nibble_driver.sv
// lcd_nibble_driver: LCD byte FIFO plus nibble sequencer with power-up init for a 4-bit HD44780
module lcd_nibble_driver
    import io_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int E_PULSE      = DEF_E_PULSE,
    parameter int NIBBLE_GAP   = DEF_NIBBLE_GAP,
    parameter int BYTE_GAP     = DEF_BYTE_GAP,
    parameter int POWERUP_WAIT = DEF_POWERUP_WAIT,
    parameter int INIT_GAP     = DEF_INIT_GAP
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [8:0]                    din,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          lcd_rs,
    output logic                          lcd_e,
    output logic [3:0]                    lcd_d
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [8:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic [8:0] cur;
    logic [1:0] idx;
    logic [31:0] cnt, lim;
    seq_state_t state, nxt;
    logic wr, pop, done, e_on, rs_n;
    logic [3:0] nib;
    assign count = wp - rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign busy  = state != S_IDLE;
    assign wr    = push && !full;
    assign pop   = state == S_IDLE && !empty;
    // INIT holds both the pulse and the following gap; the first init gap is the long one
    assign lim = state == S_PWR_WAIT ? 32'(POWERUP_WAIT - 1)
               : state == S_INIT     ? 32'(E_PULSE - 1) + (idx == 2'd0 ? 32'(INIT_GAP) : 32'(BYTE_GAP))
               : state == S_GAP      ? 32'(NIBBLE_GAP - 1)
               : state == S_WAIT     ? 32'(BYTE_GAP - 1)
               : 32'(E_PULSE - 1);
    assign done = cnt == lim;
    assign e_on = state == S_HI || state == S_LO || (state == S_INIT && cnt < 32'(E_PULSE));
    assign nib  = state == S_INIT ? (idx == 2'd3 ? 4'h2 : 4'h3) : state == S_HI ? cur[7:4] : cur[3:0];
    assign rs_n = state != S_INIT && cur[8];
    always_comb begin
        nxt = state;
        case (state)
            S_PWR_WAIT: if (done) nxt = S_INIT;
            S_INIT:     if (done && idx == 2'd3) nxt = S_IDLE;
            S_IDLE:     if (!empty) nxt = S_HI;
            S_HI:       if (done) nxt = S_GAP;
            S_GAP:      if (done) nxt = S_LO;
            S_LO:       if (done) nxt = S_WAIT;
            S_WAIT:     if (done) nxt = S_IDLE;
            default:    nxt = S_PWR_WAIT;
        endcase
    end
    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= din;
    // lcd outputs are registered one cycle behind the state so rs/d settle with the rising strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_PWR_WAIT;
            cnt    <= '0;
            idx    <= '0;
            wp     <= '0;
            rp     <= '0;
            cur    <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_d  <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || done) ? '0 : cnt + 32'd1;
            if (state == S_INIT && done) idx <= idx + 2'd1;
            if (wr) wp <= wp + (AW+1)'(1);
            if (pop) begin
                rp  <= rp + (AW+1)'(1);
                cur <= mem[rp[AW-1:0]];
            end
            lcd_e <= e_on;
            if (e_on) begin
                lcd_rs <= rs_n;
                lcd_d  <= nib;
            end
        end
    end
endmodule

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped LED register and LCD port on the shared CPU data bus
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int E_PULSE      = DEF_E_PULSE,
    parameter int NIBBLE_GAP   = DEF_NIBBLE_GAP,
    parameter int BYTE_GAP     = DEF_BYTE_GAP,
    parameter int POWERUP_WAIT = DEF_POWERUP_WAIT,
    parameter int INIT_GAP     = DEF_INIT_GAP
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic        push,
    input  logic [15:0] d_addr,
    inout  wire  [15:0] d_bus,
    output logic [7:0]  led,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [3:0]  lcd_d
);
    logic full, empty, busy;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic [15:0] word, rd_q;
    logic unused_bus;
    lcd_nibble_driver #(
        .FIFO_DEPTH(FIFO_DEPTH), .E_PULSE(E_PULSE), .NIBBLE_GAP(NIBBLE_GAP),
        .BYTE_GAP(BYTE_GAP), .POWERUP_WAIT(POWERUP_WAIT), .INIT_GAP(INIT_GAP)
    ) u_lcd (
        .clk(clk), .rst(rst), .push(push), .din(d_bus[8:0]),
        .full(full), .empty(empty), .busy(busy), .count(count),
        .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );
    assign word = d_addr == IO_LED        ? {8'h00, led}
                : d_addr == IO_STATUS     ? (16'(busy) << ST_BUSY) | (16'(empty) << ST_EMPTY) | (16'(full) << ST_FULL)
                : d_addr == IO_FIFO_COUNT ? 16'(count)
                : '0;
    assign d_bus      = read ? rd_q : 'z;
    assign lcd_rw     = 1'b0;
    assign unused_bus = ^d_bus[15:9];
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            led  <= '0;
        end else begin
            rd_q <= word;
            if (write && d_addr == IO_LED) led <= d_bus[7:0];
        end
    end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: scoreboard bench for io_bridge with shortened LCD timing
module tb_io_bridge;
    import io_bridge_pkg::*;
    localparam int EP = 2, NG = 3, BG = 5, PW = 10, IG = 5, DEPTH = 16;
    logic clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0, push = 1'b0;
    logic [15:0] d_addr = '0, drv = '0;
    logic drv_en = 1'b0;
    wire  [15:0] d_bus;
    logic [7:0] led;
    logic lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;
    int n_tests = 0, n_fail = 0;
    logic [8:0] sb [$];

    assign d_bus = drv_en ? drv : 'z;
    always #5 clk = ~clk;

    io_bridge #(
        .FIFO_DEPTH(DEPTH), .E_PULSE(EP), .NIBBLE_GAP(NG),
        .BYTE_GAP(BG), .POWERUP_WAIT(PW), .INIT_GAP(IG)
    ) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .push(push),
        .d_addr(d_addr), .d_bus(d_bus), .led(led), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
        drv_en = 1'b1; drv = v; d_addr = a; write = 1'b1;
        tick();
        write = 1'b0; drv_en = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] v);
        drv_en = 1'b1; drv = v; d_addr = IO_STATUS; push = 1'b1;
        tick();
        push = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        drv_en = 1'b0; read = 1'b1; d_addr = a;
        tick();
        v = d_bus;
    endtask

    // waits (bounded) for the next lcd_e pulse; gap counts low samples before it, w its length
    task automatic grab(output logic rs, output logic [3:0] d, output int w, output int gap, output bit stable);
        gap = 0; w = 0; stable = 1'b1;
        while (lcd_e !== 1'b1 && gap < 200) begin tick(); gap++; end
        rs = lcd_rs; d = lcd_d;
        while (lcd_e === 1'b1 && w < 200) begin
            if (lcd_rs !== rs || lcd_d !== d) stable = 1'b0;
            tick(); w++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        do_reset();
        n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led); end
        n_tests++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_e: got %b expected 0", lcd_e); end
        n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rw: got %b expected 0", lcd_rw); end
        n_tests++; if ({lcd_rs, lcd_d} !== 5'h00) begin n_fail++; $display("FAIL reset_rs_d: got %h expected 00", {lcd_rs, lcd_d}); end
        bus_read(IO_STATUS, v);
        n_tests++; if (v !== 16'h0006) begin n_fail++; $display("FAIL reset_status: got %h expected 0006", v); end
        bus_read(IO_FIFO_COUNT, v);
        n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", v); end
        read = 1'b0;
    endtask

    task automatic test_led();
        logic [15:0] v;
        bus_write(IO_LED, 16'h00AA);
        n_tests++; if (led !== 8'hAA) begin n_fail++; $display("FAIL led_write: got %h expected aa", led); end
        bus_read(16'h0010, v);
        d_addr = IO_LED;
        #1;
        n_tests++; if (d_bus !== 16'h0000) begin n_fail++; $display("FAIL read_latency: got %h expected 0000", d_bus); end
        tick();
        n_tests++; if (d_bus !== 16'h00AA) begin n_fail++; $display("FAIL led_read: got %h expected 00aa", d_bus); end
        read = 1'b0; drv_en = 1'b1; drv = 16'h5500;
        #1;
        n_tests++; if (d_bus !== 16'h5500) begin n_fail++; $display("FAIL bus_release: got %h expected 5500", d_bus); end
        drv_en = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [15:0] v;
        bus_write(16'h0010, 16'h0033);
        n_tests++; if (led !== 8'hAA) begin n_fail++; $display("FAIL unmapped_write: got %h expected aa", led); end
        bus_read(16'h0010, v);
        n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read_10: got %h expected 0000", v); end
        bus_read(16'h0100, v);
        n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read_100: got %h expected 0000", v); end
        read = 1'b0;
    endtask

    task automatic test_init();
        logic rs; logic [3:0] d; int w, gap; bit st;
        logic [3:0] exp_d [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
        int exp_gap [4] = '{0, IG, BG, BG};
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            grab(rs, d, w, gap, st);
            n_tests++; if ({rs, d} !== {1'b0, exp_d[i]}) begin n_fail++; $display("FAIL init_nibble%0d: got rs=%b d=%h expected rs=0 d=%h", i, rs, d, exp_d[i]); end
            n_tests++; if (w != EP || !st) begin n_fail++; $display("FAIL init_pulse%0d: got width %0d stable %0d expected %0d 1", i, w, st, EP); end
            if (i > 0) begin
                n_tests++; if (gap != exp_gap[i]) begin n_fail++; $display("FAIL init_gap%0d: got %0d expected %0d", i, gap, exp_gap[i]); end
            end
        end
        repeat (BG + 2) tick();
        bus_read(IO_STATUS, v);
        n_tests++; if (v !== 16'h0002) begin n_fail++; $display("FAIL init_done_status: got %h expected 0002", v); end
        read = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [15:0] v;
        logic [8:0] e;
        logic rh, rl; logic [3:0] dh, dl; int wh, wl, gh, gl; bit sh, sl;
        int skips;
        do_reset();
        sb.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            v = 16'(((i & 1) << 8) | (8'h40 + i));
            if (i < DEPTH) sb.push_back(v[8:0]);
            do_push(v);
        end
        bus_read(IO_FIFO_COUNT, v);
        n_tests++; if (v !== 16'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %h expected %h", v, 16'(DEPTH)); end
        bus_read(IO_STATUS, v);
        n_tests++; if (v !== 16'h0005) begin n_fail++; $display("FAIL full_status: got %h expected 0005", v); end
        read = 1'b0;
        skips = 0;
        do begin grab(rh, dh, wh, gh, sh); skips++; end while (!(rh === 1'b0 && dh === 4'h2) && skips < 8);
        n_tests++; if (skips >= 8) begin n_fail++; $display("FAIL full_init_seen: got %0d nibbles without 0x2 expected the last init nibble", skips); end
        for (int i = 0; i < DEPTH; i++) begin
            grab(rh, dh, wh, gh, sh);
            grab(rl, dl, wl, gl, sl);
            e = sb.size() > 0 ? sb.pop_front() : 9'h1FF;
            n_tests++; if ({rh, dh, dl} !== e) begin n_fail++; $display("FAIL full_byte%0d: got %h expected %h", i, {rh, dh, dl}, e); end
            n_tests++; if (rl !== e[8] || wh != EP || wl != EP || gl != NG || !sh || !sl) begin n_fail++; $display("FAIL full_shape%0d: got rs_lo=%b w=%0d/%0d gap=%0d stable=%0d%0d expected %b %0d/%0d %0d 11", i, rl, wh, wl, gl, sh, sl, e[8], EP, EP, NG); end
        end
        repeat (BG + 2) tick();
        bus_read(IO_STATUS, v);
        n_tests++; if (v !== 16'h0002) begin n_fail++; $display("FAIL full_drained: got %h expected 0002", v); end
        read = 1'b0;
    endtask

    task automatic test_byte_timing();
        logic rh, rl; logic [3:0] dh, dl; int wh, wl, gh, gl; bit sh, sl;
        logic [8:0] e;
        drv_en = 1'b1; drv = 16'h0141; d_addr = IO_LED; write = 1'b1; push = 1'b1;
        tick();
        write = 1'b0; push = 1'b0; drv_en = 1'b0;
        sb.push_back(9'h141);
        n_tests++; if (led !== 8'h41) begin n_fail++; $display("FAIL wp_led: got %h expected 41", led); end
        read = 1'b1; d_addr = IO_STATUS;
        grab(rh, dh, wh, gh, sh);
        e = sb.pop_front();
        n_tests++; if ({rh, dh} !== {e[8], e[7:4]} || wh != EP || !sh) begin n_fail++; $display("FAIL hi_nibble: got rs=%b d=%h w=%0d expected rs=%b d=%h w=%0d", rh, dh, wh, e[8], e[7:4], EP); end
        n_tests++; if (gh != 2) begin n_fail++; $display("FAIL pop_latency: got %0d low cycles expected 2", gh); end
        grab(rl, dl, wl, gl, sl);
        n_tests++; if ({rl, dl} !== {e[8], e[3:0]} || wl != EP || !sl) begin n_fail++; $display("FAIL lo_nibble: got rs=%b d=%h w=%0d expected rs=%b d=%h w=%0d", rl, dl, wl, e[8], e[3:0], EP); end
        n_tests++; if (gl != NG) begin n_fail++; $display("FAIL nibble_gap: got %0d expected %0d", gl, NG); end
        for (int i = 0; i < BG; i++) begin
            n_tests++; if (d_bus[ST_BUSY] !== 1'b1) begin n_fail++; $display("FAIL busy_hold%0d: got %b expected 1", i, d_bus[ST_BUSY]); end
            tick();
        end
        n_tests++; if (d_bus[ST_BUSY] !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b expected 0", d_bus[ST_BUSY]); end
        read = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int n;
        do_push(16'h0155);
        do_push(16'h0166);
        do_push(16'h0177);
        n = 0;
        while (lcd_e !== 1'b1 && n < 50) begin tick(); n++; end
        n_tests++; if (lcd_e !== 1'b1) begin n_fail++; $display("FAIL mid_start: got lcd_e=%b expected 1", lcd_e); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_tests++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL mid_lcd_e: got %b expected 0", lcd_e); end
        bus_read(IO_FIFO_COUNT, v);
        read = 1'b0;
        n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_count: got %h expected 0000", v); end
        n = 1;
        while (lcd_e !== 1'b1 && n < PW + 20) begin tick(); n++; end
        n_tests++; if (n < PW || n > PW + 1) begin n_fail++; $display("FAIL mid_restart: got first pulse %0d cycles after reset expected %0d..%0d", n, PW, PW + 1); end
        n_tests++; if ({lcd_rs, lcd_d} !== 5'h03) begin n_fail++; $display("FAIL mid_init_nibble: got rs=%b d=%h expected rs=0 d=3", lcd_rs, lcd_d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_led();
        test_unmapped();
        test_init();
        test_fifo_full();
        test_byte_timing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
